// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_LATENCY     = 3;
    localparam int unsigned NUM_LANES       = 4;
    localparam int unsigned WORD_W          = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enable write, combinational read, never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [NUM_LANES-1:0] be,
    input  logic [AW-1:0]        raddr,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency CPU data-memory responder with byte-lane writes and address error checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cap_we_q, cap_err_q;
    logic [AW-1:0]      cap_idx_q;
    logic [WORD_W-1:0]  cap_wdata_q;
    logic [NUM_LANES-1:0] cap_be_q;

    logic               accept_c;
    logic               req_err_c;
    logic               mem_we_c;
    logic [AW-1:0]      mem_waddr_c;
    logic [WORD_W-1:0]  mem_wdata_c;
    logic [NUM_LANES-1:0] mem_be_c;
    logic [WORD_W-1:0]  mem_rdata_c;

    assign accept_c  = req_i && ready_o;
    assign req_err_c = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));

    // State, counter and request capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_we_q    <= 1'b0;
            cap_err_q   <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            cap_be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_c) begin
                cap_we_q    <= we_i;
                cap_err_q   <= req_err_c;
                cap_idx_q   <= addr_i[AW+1:2];
                cap_wdata_q <= wdata_i;
                cap_be_q    <= be_i;
            end
        end
    end

    // Next state and response outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_o = (state_q == IDLE) && !rst_i;
        ack_o   = (state_q == RESP);
        err_o   = 1'b0;
        rdata_o = '0;

        case (state_q)
            IDLE: begin
                if (req_i && ready_o) begin
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                err_o   = cap_err_q;
                if (!cap_err_q && !cap_we_q) begin
                    rdata_o = mem_rdata_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write lands on the edge entering RESP; with single-cycle latency that is the accept edge itself
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = cap_idx_q;
        mem_wdata_c = cap_wdata_q;
        mem_be_c    = cap_be_q;
        if (LATENCY == 1) begin
            if (accept_c) begin
                mem_we_c    = we_i && !req_err_c;
                mem_waddr_c = addr_i[AW+1:2];
                mem_wdata_c = wdata_i;
                mem_be_c    = be_i;
            end
        end else if ((state_q == BUSY) && (cnt_q == '0)) begin
            mem_we_c = cap_we_q && !cap_err_q;
        end
        if (rst_i) begin
            mem_we_c = 1'b0;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i (clk_i),
        .we    (mem_we_c),
        .waddr (mem_waddr_c),
        .wdata (mem_wdata_c),
        .be    (mem_be_c),
        .raddr (cap_idx_q),
        .rdata (mem_rdata_c)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=3 main instance plus a LATENCY=1 instance.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        ready_o, ack_o, err_o;
    logic [31:0] rdata_o;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [3:0]  be1 = '0;
    logic        ready1, ack1, err1;
    logic [31:0] rdata1;

    int unsigned n_vec = 0, n_err = 0;
    int unsigned cyc = 0;
    int unsigned n_acks = 0, n_exp = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .ready_o(ready_o), .ack_o(ack_o),
        .rdata_o(rdata_o), .err_o(err_o)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .be_i(be1), .ready_o(ready1), .ack_o(ack1),
        .rdata_o(rdata1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every ack, checks quiet outputs otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_o) begin
                n_acks++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack_o), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rdata", rdata_o, mon_e.rdata);
                    check("err", 32'(err_o), 32'(mon_e.err));
                    check("ack_latency", cyc - mon_e.acc_cyc + 1, LAT);
                end
            end else begin
                check("idle_rdata", rdata_o, 32'd0);
                check("idle_err", 32'(err_o), 32'd0);
            end
        end
    end

    // Raise a request and wait for acceptance; expectation is queued at the accept point
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit expect_ack,
                          output int unsigned waits, output int unsigned acc);
        exp_t        e;
        logic        ee;
        logic [31:0] er;
        we_i = we; addr_i = addr; wdata_i = wdata; be_i = be; req_i = 1'b1;
        waits = 0;
        acc   = 0;
        while (!ready_o && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!ready_o) begin
            check("accept_timeout", 32'(ready_o), 32'd1);
            req_i = 1'b0;
            return;
        end
        ee = (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= DEPTH);
        er = '0;
        if (!ee) begin
            if (we) begin
                if (expect_ack) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) model[addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                er = model[addr[9:2]];
            end
        end
        acc = cyc + 1;
        if (expect_ack) begin
            e.rdata = er; e.err = ee; e.acc_cyc = acc;
            sb.push_back(e);
            n_exp++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        int unsigned w, a;
        do_req(we, addr, wdata, be, 1'b1, w, a);
        req_i = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int unsigned w, a, prev_acc, acks_before;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_ready_l1", 32'(ready1), 32'd0);

        rst = 1'b0;
        #1;
        // First request accepted on the very first edge out of reset
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, w, a);
        req_i = 1'b0;
        check("first_accept_waits", w, 32'd0);
        xact(1'b0, 32'h10, '0, 4'h0);

        xact(1'b1, 32'h20, 32'h11223344, 4'hF);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
        xact(1'b0, 32'h20, '0, 4'hF);
        drain();
        check("byte_lane_model", model[8], 32'h11BB33DD);
        xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        xact(1'b0, 32'h20, '0, 4'h0);

        xact(1'b0, 32'h13, '0, 4'hF);
        xact(1'b1, 32'(4 * DEPTH), 32'h0BADF00D, 4'hF);
        xact(1'b1, 32'h12, 32'h0BADF00D, 4'hF);
        xact(1'b0, 32'h10, '0, 4'hF);
        drain();

        // Four reads with req held high throughout
        acks_before = n_acks;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, (i % 2 == 0) ? 32'h10 : 32'h20, '0, 4'hF, 1'b1, w, a);
            if (i > 0) begin
                check("tput_busy_cycles", w, LAT);
                check("tput_accept_gap", a - prev_acc, LAT + 1);
            end
            prev_acc = a;
        end
        req_i = 1'b0;
        drain();
        check("tput_ack_count", n_acks - acks_before, 32'd4);

        // Write aborted by reset one cycle after acceptance
        xact(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        drain();
        do_req(1'b1, 32'h30, 32'h00000055, 4'hF, 1'b0, w, a);
        req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready_o), 32'd0);
        check("midrst_ack", 32'(ack_o), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_ack_held", 32'(ack_o), 32'd0);
        rst = 1'b0;
        #1;
        do_req(1'b0, 32'h30, '0, 4'hF, 1'b1, w, a);
        req_i = 1'b0;
        check("post_rst_accept_waits", w, 32'd0);
        drain();

        // Single-cycle latency instance
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h12345678; be1 = 4'hF;
        check("l1_ready_idle", 32'(ready1), 32'd1);
        @(negedge clk);
        check("l1_wr_ack", 32'(ack1), 32'd1);
        check("l1_wr_ready", 32'(ready1), 32'd0);
        check("l1_wr_err", 32'(err1), 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        check("l1_ack_clear", 32'(ack1), 32'd0);
        req1 = 1'b1; we1 = 1'b0; wdata1 = '0;
        @(negedge clk);
        check("l1_rd_ack", 32'(ack1), 32'd1);
        check("l1_rd_ready", 32'(ready1), 32'd0);
        check("l1_rd_data", rdata1, 32'h12345678);
        req1 = 1'b0;
        @(negedge clk);
        check("l1_rd_ack_clear", 32'(ack1), 32'd0);

        drain();
        repeat (2) @(negedge clk);
        check("total_acks", n_acks, n_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-high, with ports named clk_i and rst_i.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- DEPTH_WORDS, 256, number of 32-bit storage words (power of two).
- LATENCY, 3, cycles from request acceptance to ack_o; minimum value 1.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, async active-high reset.
- req_i, in, 1, CPU memory request valid.
- we_i, in, 1, 1 = write, 0 = read.
- addr_i, in, 32, byte address.
- wdata_i, in, 32, write data.
- be_i, in, 4, byte-lane write enables (bit n = bits 8n+7:8n).
- ready_o, out, 1, responder can accept a request this cycle.
- ack_o, out, 1, one-cycle response strobe.
- rdata_o, out, 32, read data; valid only while ack_o = 1.
- err_o, out, 1, response error; valid only while ack_o = 1.

Function
REQ-004 A request SHALL be accepted on a rising edge where req_i = 1 and ready_o = 1. we_i, addr_i, wdata_i and be_i SHALL be captured at that edge and SHALL be don't-care afterwards.
REQ-005 The FSM SHALL have three states: IDLE, BUSY, RESP.
- IDLE -> BUSY on acceptance when LATENCY > 1.
- IDLE -> RESP on acceptance when LATENCY = 1.
- BUSY -> RESP when the down-counter equals 0.
- RESP -> IDLE unconditionally.
REQ-006 On acceptance the counter SHALL load LATENCY-2 (when LATENCY > 1) and SHALL decrement once per cycle in BUSY.
REQ-007 ack_o SHALL be 1 exactly in the RESP cycle: one pulse, LATENCY cycles after the acceptance edge.
REQ-008 ready_o SHALL equal (state == IDLE) AND NOT rst_i, so no request is accepted in BUSY or RESP. Back-to-back throughput is therefore one request per LATENCY+1 cycles.
REQ-009 An error SHALL be flagged when captured addr[1:0] != 0 or word index addr[31:2] >= DEPTH_WORDS. In that case err_o = 1 and rdata_o = 0 in RESP, and no storage word is modified.
REQ-010 A valid write SHALL update only the byte lanes enabled in be_i, at the edge entering RESP. A write with be_i = 0 SHALL modify nothing and SHALL still be acked.
REQ-011 A valid read SHALL return the full addressed word (be_i ignored), reflecting all writes acked before its acceptance.
REQ-012 Outside RESP, rdata_o SHALL be 0 and err_o SHALL be 0.
REQ-013 req_i asserted while ready_o = 0 SHALL be ignored; the requester holds it until acceptance.

Reset
REQ-014 While rst_i = 1 the outputs SHALL be: state = IDLE, counter = 0, ready_o = 0, ack_o = 0, err_o = 0, rdata_o = 0.
REQ-015 Reset asserted mid-operation (BUSY or RESP-entry) SHALL abort the transaction: no ack_o and no storage write.
REQ-016 Storage contents SHALL NOT be cleared by reset and are undefined at power-up.
REQ-017 The first acceptance after reset SHALL be possible on the first rising edge with rst_i = 0.

Structure
REQ-018 A shared package dmem_pkg SHALL hold:
- the FSM state enum;
- default DEPTH_WORDS and LATENCY constants;
- the byte-lane count (4).
REQ-019 Storage SHALL be a sub-module dmem_array: synchronous byte-enable write and combinational read, with no reset port.
REQ-020 The counter width SHALL be $clog2(LATENCY) with a minimum of 1 bit.

Verification
REQ-021 Write then read, LATENCY = 3: write 0xDEADBEEF to 0x10 with be = 0xF, then read 0x10. Required response: each ack_o occurs 3 cycles after acceptance; the read gives rdata_o = 0xDEADBEEF with err_o = 0.
REQ-022 Byte-lane write: write 0x11223344 to 0x20 with be = 0xF, then write 0xAABBCCDD with be = 0x5, then read. Required response: rdata_o = 0x11BB33DD.
REQ-023 Error cases: read at 0x13 (misaligned), and write at 4*DEPTH_WORDS (out of range). Required response: ack_o with err_o = 1 and rdata_o = 0; the word at 0x10 is unchanged on a later read.
REQ-024 Throughput: hold req_i = 1 continuously for 4 reads, LATENCY = 3. Required response: acceptances 4 cycles apart, ready_o = 0 during BUSY/RESP, and exactly 4 ack pulses.
REQ-025 Reset mid-write: accept a write of 0x55 to 0x30, then assert rst_i 1 cycle later. Required response: no ack_o; a read of 0x30 after reset returns the value written before the aborted write.
REQ-026 LATENCY = 1 build: a read accepted at edge k SHALL produce ack_o in cycle k+1, with ready_o = 0 in that cycle.
